fifo_reader: RTL and testbench

Read-side drain engine for the codebase's synchronous FIFO (registered read port, one-cycle read latency). It issues `read_en` pops against the FIFO's `empty` flag and absorbs the read latency in a small holding buffer. It presents entries to the consumer (decode/dispatch) on a valid/ready stream at full throughput. It also supports a pipeline flush that discards buffered and in-flight entries.

---
 rtl/fifo_pkg.sv | 13 +
 rtl/fifo_reader_hold_queue.sv | 71 +++++++
 rtl/fifo_reader.sv | 66 ++++++
 tb/tb_fifo_reader.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: default entry type, reader buffer depth, pointer sizing.
package fifo_pkg;

  typedef logic [31:0] fifo_word_t;

  localparam int unsigned FIFO_READER_BUF_DEPTH = 2;

  // Pointer width for a circular buffer of the given depth (at least 1 bit).
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/fifo_reader_hold_queue.sv
// hold_queue: small circular buffer with push/pop/clear, occupancy count and head data.
// Clear and reset take priority over push and pop; reset also zeroes the storage.
module hold_queue
  import fifo_pkg::*;
#(
  parameter type         T     = fifo_word_t,
  parameter int unsigned DEPTH = FIFO_READER_BUF_DEPTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       push,
  input  T                           push_data,
  input  logic                       pop,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output T                           head_data
);

  localparam int unsigned PW = ptr_width(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  T              r_mem [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic          w_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A pop on an empty queue is ignored; pushes always have room because the
  // caller only requests data it can hold.
  assign w_pop = pop && (r_count != '0);

  // Entry storage: cleared on reset, written at the tail on push.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (!clear && push) begin
      r_mem[r_tail] <= push_data;
    end
  end

  // Pointer and occupancy update; simultaneous push and pop keep count.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (push) begin
        r_tail <= next_ptr(r_tail);
      end
      if (w_pop) begin
        r_head <= next_ptr(r_head);
      end
      if (push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!push && w_pop) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  assign count     = r_count;
  assign head_data = r_mem[r_head];

endmodule

// File: rtl/fifo_reader.sv
// fifo_reader: drains a registered-read FIFO into a valid/ready stream,
// absorbing the one-cycle read latency in a hold_queue. Supports flush.
module fifo_reader
  import fifo_pkg::*;
#(
  parameter type         T         = fifo_word_t,
  parameter int unsigned BUF_DEPTH = FIFO_READER_BUF_DEPTH
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           fifo_empty,
  input  T                               fifo_read_data,
  output logic                           fifo_read_en,
  input  logic                           flush,
  output logic                           out_valid,
  output T                               out_data,
  input  logic                           out_ready,
  output logic [$clog2(BUF_DEPTH+1)-1:0] buf_count
);

  localparam int unsigned CW = $clog2(BUF_DEPTH + 1);

  logic          r_inflight;
  logic [CW-1:0] w_count;
  logic          w_pop;
  logic          w_capture;
  logic [CW:0]   w_occupancy;

  assign out_valid = (w_count != '0);
  assign w_pop     = out_valid && out_ready;

  // Entries held plus the one in flight, minus the one leaving this cycle;
  // a new pop is only issued when that leaves room for its data.
  assign w_occupancy  = {1'b0, w_count} + (CW+1)'(r_inflight) - (CW+1)'(w_pop);
  assign fifo_read_en = !reset && !flush && !fifo_empty &&
                        (w_occupancy < (CW+1)'(BUF_DEPTH));

  // Data returned for a pop issued just before a flush is dropped.
  assign w_capture = r_inflight && !flush;

  // Remember that a pop was issued so its data is captured next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= fifo_read_en;
    end
  end

  hold_queue #(
    .T     (T),
    .DEPTH (BUF_DEPTH)
  ) u_hold (
    .clk       (clk),
    .reset     (reset),
    .clear     (flush),
    .push      (w_capture),
    .push_data (fifo_read_data),
    .pop       (w_pop),
    .count     (w_count),
    .head_data (out_data)
  );

  assign buf_count = w_count;

endmodule

// File: tb/tb_fifo_reader.sv
// Bench for fifo_reader: a behavioural depth-8 FIFO feeds the reader; a
// scoreboard records every entry popped from the FIFO and a monitor compares
// it against each accepted output, discarding held entries on flush/reset.
module tb_fifo_reader;
  import fifo_pkg::*;

  localparam int unsigned BD = FIFO_READER_BUF_DEPTH;
  localparam int unsigned CW = $clog2(BD + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          fifo_empty;
  fifo_word_t    fifo_read_data;
  logic          fifo_read_en;
  logic          flush;
  logic          out_valid;
  fifo_word_t    out_data;
  logic          out_ready;
  logic [CW-1:0] buf_count;

  always #5 clk = ~clk;

  fifo_reader #(
    .T         (fifo_word_t),
    .BUF_DEPTH (BD)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .fifo_empty     (fifo_empty),
    .fifo_read_data (fifo_read_data),
    .fifo_read_en   (fifo_read_en),
    .flush          (flush),
    .out_valid      (out_valid),
    .out_data       (out_data),
    .out_ready      (out_ready),
    .buf_count      (buf_count)
  );

  // Behavioural synchronous FIFO, depth 8, registered read port.
  fifo_word_t  fmem [8];
  int unsigned f_wr, f_rd, f_cnt;
  logic        wr_en;
  fifo_word_t  wr_data;

  assign fifo_empty = (f_cnt == 0);

  always @(posedge clk) begin
    if (reset) begin
      f_wr <= 0; f_rd <= 0; f_cnt <= 0;
      fifo_read_data <= '0;
    end else begin
      if (wr_en && f_cnt < 8) begin
        fmem[f_wr] <= wr_data;
        f_wr <= (f_wr + 1) % 8;
      end
      if (fifo_read_en && f_cnt != 0) begin
        fifo_read_data <= fmem[f_rd];
        f_rd <= (f_rd + 1) % 8;
      end
      f_cnt <= f_cnt + ((wr_en && f_cnt < 8) ? 1 : 0) - ((fifo_read_en && f_cnt != 0) ? 1 : 0);
    end
  end

  int         checks = 0;
  int         errors = 0;
  fifo_word_t sb [$];
  int         delivered = 0;
  int         pops = 0;
  int         vcycles = 0;
  int         max_cnt = 0;
  fifo_word_t last_val = '0;

  // Monitor: samples mid-cycle, so the values seen are those the next edge uses.
  always @(negedge clk) begin
    fifo_word_t exp_v;
    if (int'(buf_count) > max_cnt) max_cnt = int'(buf_count);
    if (reset || flush) begin
      sb.delete();
    end else begin
      if (out_valid) vcycles++;
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected got %0h expected nothing", out_data);
        end else begin
          exp_v = sb.pop_front();
          if (out_data !== exp_v) begin
            errors++;
            $display("FAIL sb_data got %0h expected %0h", out_data, exp_v);
          end
        end
        delivered++;
        last_val = out_data;
      end
      if (fifo_read_en) begin
        pops++;
        if (f_cnt == 0) begin
          checks++;
          errors++;
          $display("FAIL pop_when_empty got read_en=1 expected 0");
        end else begin
          sb.push_back(fmem[f_rd]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int target, input int budget, input string name);
    for (int c = 0; c < budget && delivered < target; c++) step();
    chk(name, delivered, target);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, p0, v0, re_c, v_c, first_h, last_h;
    logic stable, found;

    reset = 1'b1; flush = 1'b0; out_ready = 1'b0; wr_en = 1'b0; wr_data = '0;
    step(); step();
    chk("rst_read_en", fifo_read_en, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_count", buf_count, 0);
    reset = 1'b0;
    step();

    // Streaming 0..7 with consumer always ready.
    out_ready = 1'b1; d0 = delivered;
    re_c = -1; v_c = -1; first_h = -1; last_h = -1;
    for (int c = 0; c < 30; c++) begin
      wr_en = (c < 8); wr_data = c;
      @(negedge clk);
      if (fifo_read_en && re_c < 0) re_c = c;
      if (out_valid && v_c < 0) v_c = c;
      if (out_valid) begin
        if (first_h < 0) first_h = c;
        last_h = c;
      end
      step();
    end
    chk("t1_latency", v_c - re_c, 2);
    chk("t1_count", delivered - d0, 8);
    chk("t1_consecutive", last_h - first_h, 7);
    chk("t1_empty", fifo_empty, 1);
    chk("t1_idle_valid", out_valid, 0);

    // Consumer stalled: exactly two pops fill the buffer.
    out_ready = 1'b0; d0 = delivered; p0 = pops;
    for (int c = 0; c < 8; c++) begin
      wr_en = 1'b1; wr_data = c; step();
    end
    wr_en = 1'b0;
    stable = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c >= 2 && (out_data !== 32'd0 || out_valid !== 1'b1)) stable = 1'b0;
      step();
    end
    chk("t2_pops", pops - p0, 2);
    chk("t2_buf_count", buf_count, 2);
    chk("t2_fifo_left", f_cnt, 6);
    chk("t2_head", out_data, 0);
    chk("t2_stable", stable, 1);
    out_ready = 1'b1;
    drain(d0 + 8, 40, "t2_delivered");

    // Consumer ready toggling every cycle.
    d0 = delivered; max_cnt = 0;
    for (int c = 0; c < 80 && delivered < d0 + 8; c++) begin
      wr_en = (c < 8); wr_data = 32'h100 + c;
      out_ready = (c % 2 == 0);
      step();
    end
    wr_en = 1'b0;
    chk("t3_delivered", delivered - d0, 8);
    chk("t3_max_count", max_cnt <= int'(BD), 1);

    // Flush while entry 3 is at the head: 3 and in-flight 4 are dropped.
    out_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      wr_en = 1'b1; wr_data = c; step();
    end
    wr_en = 1'b0; step(); step();
    d0 = delivered; found = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 20 && !found; c++) begin
      step();
      if (out_valid && out_data == 32'd3) begin
        flush = 1'b1; found = 1'b1;
        #1;
        chk("t4_read_en_in_flush", fifo_read_en, 0);
        step();
        flush = 1'b0;
        chk("t4_count_after", buf_count, 0);
      end
    end
    chk("t4_found", found, 1);
    p0 = delivered;
    for (int c = 0; c < 20 && delivered == p0; c++) step();
    chk("t4_next_value", last_val, 5);
    drain(d0 + 6, 30, "t4_delivered");

    // Reset in the middle of a stream.
    for (int c = 0; c < 4; c++) begin
      wr_en = 1'b1; wr_data = 32'h200 + c; step();
    end
    wr_en = 1'b0;
    chk("t5_mid_valid", out_valid, 1);
    reset = 1'b1;
    #1;
    chk("t5_read_en_in_reset", fifo_read_en, 0);
    step();
    chk("t5_valid", out_valid, 0);
    chk("t5_count", buf_count, 0);
    chk("t5_data", out_data, 0);
    chk("t5_read_en", fifo_read_en, 0);
    step();
    reset = 1'b0;
    step();

    // Single entry.
    p0 = pops; v0 = vcycles;
    wr_en = 1'b1; wr_data = 32'hA5; step();
    wr_en = 1'b0;
    for (int c = 0; c < 10; c++) step();
    chk("t6_pops", pops - p0, 1);
    chk("t6_valid_cycles", vcycles - v0, 1);
    chk("t6_value", last_val, 32'hA5);
    chk("t6_idle_read_en", fifo_read_en, 0);

    // Random traffic with occasional flushes.
    max_cnt = 0;
    for (int c = 0; c < 1500; c++) begin
      wr_en = ($urandom_range(0, 3) != 0) && (f_cnt < 7);
      wr_data = $urandom;
      out_ready = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 39) == 0);
      step();
    end
    wr_en = 1'b0; flush = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 30; c++) step();
    chk("rnd_sb_drained", sb.size(), 0);
    chk("rnd_fifo_empty", fifo_empty, 1);
    chk("rnd_max_count", max_cnt <= int'(BD), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
